// File: rtl/mips_decode_pkg.sv
// Shared types and constants for the MIPS ALU-instruction decode pipe:
// opcode/funct encodings, ALU control codes, and the decoded queue entry.
package mips_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [2:0] {
    ALU_NONE = 3'b000,
    ALU_ADD  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_NOR  = 3'b110,
    ALU_XOR  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC2_REG  = 2'd0,
    SRC2_ZEXT = 2'd1,
    SRC2_SEXT = 2'd2
  } alu_src2_e;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic        except;
    logic        rd_src;
    logic [4:0]  wr_reg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        writeenable;
    alu_src2_e   alu_src2;
    alu_op_e     alu_op;
    logic [31:0] imm32;
  } decode_entry_t;

  // Decode one instruction word; unrecognized words yield an inert entry
  // with only except set (rs/rt are still carried for debug visibility).
  function automatic decode_entry_t decode_inst(input logic [31:0] inst);
    decode_entry_t e;
    e        = '0;
    e.rs     = inst[25:21];
    e.rt     = inst[20:16];
    case (inst[31:26])
      OP_RTYPE: begin
        case (inst[5:0])
          FN_ADD:  e.alu_op = ALU_ADD;
          FN_SUB:  e.alu_op = ALU_SUB;
          FN_AND:  e.alu_op = ALU_AND;
          FN_OR:   e.alu_op = ALU_OR;
          FN_NOR:  e.alu_op = ALU_NOR;
          FN_XOR:  e.alu_op = ALU_XOR;
          default: e.except = 1'b1;
        endcase
      end
      OP_ADDI: begin
        e.alu_op   = ALU_ADD;
        e.alu_src2 = SRC2_SEXT;
        e.rd_src   = 1'b1;
        e.imm32    = {{16{inst[15]}}, inst[15:0]};
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        e.alu_op   = (inst[31:26] == OP_ANDI) ? ALU_AND :
                     (inst[31:26] == OP_ORI)  ? ALU_OR  : ALU_XOR;
        e.alu_src2 = SRC2_ZEXT;
        e.rd_src   = 1'b1;
        e.imm32    = {16'h0000, inst[15:0]};
      end
      default: e.except = 1'b1;
    endcase
    if (!e.except) begin
      e.writeenable = 1'b1;
      e.wr_reg      = e.rd_src ? inst[20:16] : inst[15:11];
    end
    return e;
  endfunction

endpackage

// File: rtl/mips_decode_pipe_if.sv
// Handshake and decoded-field bundle between the decode pipe (slave) and its
// producer/consumer environment (master).
interface mips_decode_pipe_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst;
  logic             out_valid;
  logic             out_ready;
  logic             rd_src;
  logic [4:0]       wr_reg;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             writeenable;
  logic [1:0]       alu_src2;
  logic [2:0]       alu_op;
  logic [31:0]      imm32;
  logic             except;
  logic [CNT_W-1:0] except_cnt;
  logic             halted;
  logic             except_clr;

  modport slave (
    input  in_valid, inst, out_ready, except_clr,
    output in_ready, out_valid, rd_src, wr_reg, rs, rt, writeenable,
           alu_src2, alu_op, imm32, except, except_cnt, halted
  );

  modport master (
    output in_valid, inst, out_ready, except_clr,
    input  in_ready, out_valid, rd_src, wr_reg, rs, rt, writeenable,
           alu_src2, alu_op, imm32, except, except_cnt, halted
  );
endinterface

// File: rtl/mips_decode_pipe_fifo.sv
// Output queue of decoded entries. has_space is registered from the next
// occupancy so a same-cycle pop never opens the input when full.
module decode_fifo
  import mips_decode_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  decode_entry_t din,
  output decode_entry_t dout,
  output logic          not_empty,
  output logic          has_space
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  decode_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          do_push, do_pop;

  assign do_push   = push && (count != FULL_CNT);
  assign do_pop    = pop && (count != '0);
  assign not_empty = (count != '0);
  assign dout      = not_empty ? mem[rd_ptr] : '0;

  // Next occupancy from this cycle's transfers.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy and the registered space flag; pointers wrap at DEPTH (power of two).
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      has_space <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count     <= count_next;
      has_space <= (count_next != FULL_CNT);
    end
  end

  // Entry storage.
  always_ff @(posedge clock) begin
    // NOTE: storage is deliberately not reset; stale entries are masked by not_empty.
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mips_decode_pipe.sv
// MIPS ALU-instruction decoder feeding a small output queue, with an
// exception counter and a RUN/HALTED control FSM that stops intake on
// an unrecognized instruction.
module mips_decode_pipe
  import mips_decode_pkg::*;
#(
  parameter int DEPTH          = 2,
  parameter int CNT_W          = 8,
  parameter bit HALT_ON_EXCEPT = 1'b1
) (
  input logic               clock,
  input logic               reset,
  mips_decode_pipe_if.slave bus
);
  ctrl_state_e      state;
  logic [CNT_W-1:0] except_cnt;
  decode_entry_t    dec, head;
  logic             has_space, not_empty;
  logic             accept, pop, accept_exc;

  assign dec        = decode_inst(bus.inst);
  assign bus.in_ready = has_space && (state == RUN);
  assign accept     = bus.in_valid && bus.in_ready;
  assign pop        = not_empty && bus.out_ready;
  assign accept_exc = accept && dec.except;

  decode_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .pop       (pop),
    .din       (dec),
    .dout      (head),
    .not_empty (not_empty),
    .has_space (has_space)
  );

  // Control FSM and saturating exception counter; a clear that coincides
  // with an accepted exception counts that exception afresh.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= RUN;
      except_cnt <= '0;
    end else begin
      if (accept_exc && HALT_ON_EXCEPT) state <= HALTED;
      else if (bus.except_clr)          state <= RUN;

      if (bus.except_clr)
        except_cnt <= accept_exc ? CNT_W'(1) : '0;
      else if (accept_exc && (except_cnt != '1))
        except_cnt <= except_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid   = not_empty;
  assign bus.rd_src      = head.rd_src;
  assign bus.wr_reg      = head.wr_reg;
  assign bus.rs          = head.rs;
  assign bus.rt          = head.rt;
  assign bus.writeenable = head.writeenable;
  assign bus.alu_src2    = head.alu_src2;
  assign bus.alu_op      = head.alu_op;
  assign bus.imm32       = head.imm32;
  assign bus.except      = head.except;
  assign bus.except_cnt  = except_cnt;
  assign bus.halted      = (state == HALTED);

endmodule

// File: tb/tb_mips_decode_pipe.sv
// Directed bench: default-parameter instance (a) for decode, flow control,
// halting and reset; CNT_W=2 / no-halt instance (b) for counter saturation.
module tb_mips_decode_pipe;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [31:0] I_ADDI = 32'h2128FFFC; // addi $8,$9,-4
  localparam logic [31:0] I_ORI  = 32'h35288000; // ori  $8,$9,0x8000
  localparam logic [31:0] I_NOR  = 32'h00221827; // nor  $3,$1,$2
  localparam logic [31:0] I_SUB  = 32'h00C72822; // sub  $5,$6,$7
  localparam logic [31:0] I_LW   = 32'h8D280004; // lw (opcode 0x23, unrecognized)
  localparam logic [31:0] I_BAD  = 32'hFC000000; // opcode 0x3F

  mips_decode_pipe_if #(.CNT_W(8)) bus_a ();
  mips_decode_pipe_if #(.CNT_W(2)) bus_b ();

  mips_decode_pipe #(.DEPTH(2), .CNT_W(8), .HALT_ON_EXCEPT(1'b1)) dut_a (
    .clock (clock), .reset (reset), .bus (bus_a)
  );
  mips_decode_pipe #(.DEPTH(2), .CNT_W(2), .HALT_ON_EXCEPT(1'b0)) dut_b (
    .clock (clock), .reset (reset), .bus (bus_b)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare the full head entry of instance a.
  task automatic check_head_a(input string tag, input int op, input int src2, input int rds,
                              input int wr, input logic [31:0] imm, input int we, input int exc);
    check({tag, ".out_valid"},   32'(bus_a.out_valid), 32'd1);
    check({tag, ".alu_op"},      32'(bus_a.alu_op), op);
    check({tag, ".alu_src2"},    32'(bus_a.alu_src2), src2);
    check({tag, ".rd_src"},      32'(bus_a.rd_src), rds);
    check({tag, ".wr_reg"},      32'(bus_a.wr_reg), wr);
    check({tag, ".imm32"},       bus_a.imm32, imm);
    check({tag, ".writeenable"}, 32'(bus_a.writeenable), we);
    check({tag, ".except"},      32'(bus_a.except), exc);
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.inst = '0; bus_a.out_ready = 1'b0; bus_a.except_clr = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.inst = '0; bus_b.out_ready = 1'b0; bus_b.except_clr = 1'b0;

    // Reset state
    tick(); tick();
    check("rst.out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst.in_ready",  32'(bus_a.in_ready), 32'd0);
    check("rst.halted",    32'(bus_a.halted), 32'd0);
    check("rst.cnt",       32'(bus_a.except_cnt), 32'd0);
    check("rst.imm32",     bus_a.imm32, 32'd0);
    reset = 1'b1;
    tick();
    check("rel.in_ready",  32'(bus_a.in_ready), 32'd1);
    check("rel.b_ready",   32'(bus_b.in_ready), 32'd1);

    // addi: latency 1, sign-extended immediate, rt destination
    bus_a.in_valid = 1'b1; bus_a.inst = I_ADDI;
    tick();
    bus_a.in_valid = 1'b0;
    check_head_a("addi", 2, 2, 1, 8, 32'hFFFFFFFC, 1, 0);
    check("addi.rs", 32'(bus_a.rs), 32'd9);
    bus_a.out_ready = 1'b1; tick(); bus_a.out_ready = 1'b0;
    check("addi.drained", 32'(bus_a.out_valid), 32'd0);

    // ori then nor back-to-back; head holds while not popped
    bus_a.in_valid = 1'b1; bus_a.inst = I_ORI; tick();
    bus_a.inst = I_NOR; tick();
    bus_a.in_valid = 1'b0;
    check("full.in_ready", 32'(bus_a.in_ready), 32'd0);
    check_head_a("ori", 5, 1, 1, 8, 32'h00008000, 1, 0);
    tick();
    check_head_a("ori_hold", 5, 1, 1, 8, 32'h00008000, 1, 0);
    bus_a.out_ready = 1'b1; tick(); bus_a.out_ready = 1'b0;
    check_head_a("nor", 6, 0, 0, 3, 32'h0, 1, 0);
    bus_a.out_ready = 1'b1; tick(); bus_a.out_ready = 1'b0;
    check("nor.drained", 32'(bus_a.out_valid), 32'd0);

    // Three back-to-back pushes into a depth-2 queue with a same-cycle pop
    bus_a.in_valid = 1'b1; bus_a.inst = I_SUB; tick();
    bus_a.inst = I_ADDI; tick();
    bus_a.inst = I_ORI;
    check("bp.in_ready_full", 32'(bus_a.in_ready), 32'd0);
    bus_a.out_ready = 1'b1; tick(); bus_a.out_ready = 1'b0;
    check("bp.in_ready_after_pop", 32'(bus_a.in_ready), 32'd1);
    check("bp.head_is_addi", 32'(bus_a.alu_src2), 32'd2);
    tick();
    bus_a.in_valid = 1'b0;
    check("bp.third_accepted", 32'(bus_a.in_ready), 32'd0);
    bus_a.out_ready = 1'b1; tick();
    check_head_a("bp.third", 5, 1, 1, 8, 32'h00008000, 1, 0);
    tick(); bus_a.out_ready = 1'b0;
    check("bp.drained", 32'(bus_a.out_valid), 32'd0);

    // Unrecognized opcode halts intake; queue still drains; clear resumes
    bus_a.in_valid = 1'b1; bus_a.inst = I_LW; tick();
    check_head_a("exc", 0, 0, 0, 0, 32'h0, 0, 1);
    check("exc.cnt",      32'(bus_a.except_cnt), 32'd1);
    check("exc.halted",   32'(bus_a.halted), 32'd1);
    check("exc.in_ready", 32'(bus_a.in_ready), 32'd0);
    bus_a.inst = I_ADDI; bus_a.out_ready = 1'b1; tick();
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    check("halt.drained",  32'(bus_a.out_valid), 32'd0);
    check("halt.held",     32'(bus_a.halted), 32'd1);
    bus_a.except_clr = 1'b1; tick(); bus_a.except_clr = 1'b0;
    check("clr.halted",   32'(bus_a.halted), 32'd0);
    check("clr.cnt",      32'(bus_a.except_cnt), 32'd0);
    check("clr.in_ready", 32'(bus_a.in_ready), 32'd1);

    // Clear coinciding with an accepted exception
    bus_a.in_valid = 1'b1; bus_a.inst = I_LW; bus_a.except_clr = 1'b1; tick();
    bus_a.in_valid = 1'b0; bus_a.except_clr = 1'b0;
    check("clrexc.cnt",    32'(bus_a.except_cnt), 32'd1);
    check("clrexc.halted", 32'(bus_a.halted), 32'd1);
    bus_a.out_ready = 1'b1; bus_a.except_clr = 1'b1; tick();
    bus_a.out_ready = 1'b0; bus_a.except_clr = 1'b0;
    check("clrexc.resume", 32'(bus_a.halted), 32'd0);

    // Counter saturation without halting (instance b)
    bus_b.out_ready = 1'b1; bus_b.in_valid = 1'b1; bus_b.inst = I_BAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat.cnt%0d", i), 32'(bus_b.except_cnt), (i < 2) ? i + 1 : 3);
    end
    check("sat.except",   32'(bus_b.except), 32'd1);
    check("sat.halted",   32'(bus_b.halted), 32'd0);
    check("sat.in_ready", 32'(bus_b.in_ready), 32'd1);
    bus_b.except_clr = 1'b1; tick();
    check("sat.clr_accept", 32'(bus_b.except_cnt), 32'd1);
    bus_b.in_valid = 1'b0; tick(); bus_b.except_clr = 1'b0;
    check("sat.clr", 32'(bus_b.except_cnt), 32'd0);
    bus_b.out_ready = 1'b0;

    // Reset mid-operation discards a full queue
    bus_a.in_valid = 1'b1; bus_a.inst = I_ADDI; tick();
    bus_a.inst = I_ORI; tick();
    bus_a.in_valid = 1'b0;
    check("mid.full_valid", 32'(bus_a.out_valid), 32'd1);
    check("mid.full_ready", 32'(bus_a.in_ready), 32'd0);
    reset = 1'b0; tick();
    check("mid.rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("mid.rst_ready", 32'(bus_a.in_ready), 32'd0);
    check("mid.rst_imm",   bus_a.imm32, 32'd0);
    reset = 1'b1; tick();
    check("mid.rel_valid", 32'(bus_a.out_valid), 32'd0);
    check("mid.rel_ready", 32'(bus_a.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_decode_pipe.md
MIPS_DECODE_PIPE -- requirements
Module: mips_decode_pipe

Interface
REQ-001 Parameters SHALL be: DEPTH, default 2, output-queue entries (power of two, 2..8); CNT_W, default 8, exception-counter width; HALT_ON_EXCEPT, default 1, stop accepting after an unrecognized instruction.
REQ-002 Ports SHALL be: clock  in  1  single clock, all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 in_valid  in  1  producer offers inst; in_ready  out  1  block can accept.
REQ-005 inst  in  32  MIPS instruction word (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0], funct [5:0]).
REQ-006 out_valid  out  1  head entry valid; out_ready  in  1  consumer takes head.
REQ-007 rd_src  out  1  0 = rd, 1 = rt; wr_reg  out  5  selected destination register; rs, rt  out  5 each.
REQ-008 writeenable  out  1; alu_src2  out  2 (0 reg, 1 zero-ext imm, 2 sign-ext imm); alu_op  out  3; imm32  out  32  extended immediate per alu_src2 (0 when alu_src2 = 0).
REQ-009 except  out  1  head entry unrecognized; except_cnt  out  CNT_W  accepted-exception count; halted  out  1; except_clr  in  1  clear counter and halt.

Function
REQ-010 Recognized set SHALL be opcode 0 with funct add/sub/and/or/nor/xor, and opcodes addi/andi/ori/xori; everything else SHALL set except.
REQ-011 alu_op SHALL be add 010, sub 011, and 100, or 101, nor 110, xor 111; immediate forms use their R-type code.
REQ-012 addi SHALL use alu_src2 = 2 (sign extension); andi/ori/xori alu_src2 = 1 (zero extension); R-type alu_src2 = 0.
REQ-013 rd_src SHALL be 1 exactly for immediate forms; writeenable SHALL be 1 for every recognized instruction and 0 when except = 1.
REQ-014 For except = 1 the entry SHALL carry rd_src 0, alu_src2 0, alu_op 000, imm32 0, wr_reg 0.
REQ-015 Transfer in SHALL occur when in_valid and in_ready are both high; the decoded entry SHALL be visible at the queue head no earlier than the next cycle (latency 1 when queue empty).
REQ-016 Transfer out SHALL occur when out_valid and out_ready are both high; outputs SHALL hold stable while out_valid and not out_ready.
REQ-017 in_ready SHALL be registered-state only: high iff occupancy < DEPTH and not halted; a pop in the same cycle SHALL NOT raise in_ready when full.
REQ-018 Simultaneous push and pop SHALL keep occupancy unchanged; pointers wrap modulo DEPTH.
REQ-019 Control FSM SHALL have states RUN and HALTED; RUN -> HALTED when an except instruction is accepted and HALT_ON_EXCEPT = 1; HALTED -> RUN on except_clr.
REQ-020 Queue SHALL keep draining in HALTED; halted output = (state == HALTED).
REQ-021 except_cnt SHALL increment on each accepted except instruction and saturate at all ones.
REQ-022 except_clr SHALL zero except_cnt and force RUN; if an except instruction is accepted in the same cycle, the result SHALL be except_cnt = 1 and HALTED (when HALT_ON_EXCEPT = 1).
REQ-023 With HALT_ON_EXCEPT = 0 the FSM SHALL remain in RUN; counting still applies.

Reset
REQ-024 While reset = 0 at a clock edge: occupancy 0, pointers 0, state RUN, except_cnt 0.
REQ-025 Reset outputs: out_valid 0, in_ready 0 during reset, 1 on the first cycle after release; halted 0; payload outputs 0.
REQ-026 Reset mid-operation SHALL discard all queued entries with no transfer out.

Structure
REQ-027 Package mips_decode_pkg SHALL hold opcode/funct constants, alu_op codes, alu_src2 codes and the decoded-entry struct typedef.
REQ-028 Queue storage SHALL be a sub-module decode_fifo (parameter DEPTH, entry width from the package typedef); decode logic and FSM stay in mips_decode_pipe.

Verification
REQ-029 Reset release, push addi $8,$9,-4 (0x2128FFFC) -> next cycle out_valid 1, alu_op 010, alu_src2 2, rd_src 1, wr_reg 8, imm32 0xFFFFFFFC.
REQ-030 Push ori $8,$9,0x8000 -> alu_op 101, alu_src2 1, imm32 0x00008000; push R-type nor $3,$1,$2 -> alu_op 110, wr_reg 3, writeenable 1.
REQ-031 DEPTH 2, out_ready 0, push 3 back-to-back -> in_ready 0 after 2 accepted; pop with push asserted same cycle -> third accepted only the cycle after.
REQ-032 Push opcode 0x23 -> except 1, writeenable 0, except_cnt 1, halted 1, in_ready 0; queue drains; except_clr -> halted 0, cnt 0 next cycle.
REQ-033 CNT_W 2, HALT_ON_EXCEPT 0, 5 illegal instructions -> except_cnt sticks at 3; except_clr with a concurrent illegal accept -> cnt 1.
REQ-034 Fill queue, assert reset for one cycle -> out_valid 0, occupancy 0, nothing popped.
